// File: rtl/musa_pkg.sv
// Shared execute-path constants: ALU function codes and the flag bit positions
// within the ALU's 35-bit result bus.
package musa_pkg;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_MUL = 6'b011000;
    localparam logic [5:0] FUNC_DIV = 6'b011010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOT = 6'b100111;

    localparam int FLAG_ABOVE  = 32;
    localparam int FLAG_EQUALS = 33;
    localparam int FLAG_OVF    = 34;

    // Arithmetic ops are the only ones whose overflow bit is architecturally meaningful.
    function automatic logic updates_ovf(input logic [5:0] func);
        return (func == FUNC_ADD) || (func == FUNC_SUB) ||
               (func == FUNC_MUL) || (func == FUNC_DIV);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-entry synchronous queue holding pending register-file writes.
// Slot 0 is always the head; a pop shifts slot 1 down.
module wb_fifo
    import musa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [REG_W-1:0]  push_rd,
    input  logic              push_we,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic [REG_W-1:0]  head_rd,
    output logic              head_we
);

    logic [DATA_W-1:0] data_q [2];
    logic [REG_W-1:0]  rd_q   [2];
    logic              we_q   [2];
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
                we_q[i]   <= 1'b0;
            end
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    data_q[count[0]] <= push_data;
                    rd_q[count[0]]   <= push_rd;
                    we_q[count[0]]   <= push_we;
                    count            <= count + 2'd1;
                end
                2'b01: begin
                    data_q[0] <= data_q[1];
                    rd_q[0]   <= rd_q[1];
                    we_q[0]   <= we_q[1];
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // Replace the departing head; when full the tail moves up behind it.
                    if (count == 2'd1) begin
                        data_q[0] <= push_data;
                        rd_q[0]   <= push_rd;
                        we_q[0]   <= push_we;
                    end else begin
                        data_q[0] <= data_q[1];
                        rd_q[0]   <= rd_q[1];
                        we_q[0]   <= we_q[1];
                        data_q[1] <= push_data;
                        rd_q[1]   <= push_rd;
                        we_q[1]   <= push_we;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = data_q[0];
    assign head_rd   = rd_q[0];
    assign head_we   = we_q[0];

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage after the ALU: queues register writes, maintains the status
// flags, and raises a sticky overflow exception that stalls intake.
module alu_writeback
    import musa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W+2:0] in_result,
    input  logic [5:0]        in_func,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wen,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rf_ready,
    output logic [2:0]        flags,
    output logic              exc_pending,
    output logic [5:0]        exc_func,
    output logic [REG_W-1:0]  exc_rd,
    input  logic              exc_clear
);

    logic [1:0]        count;
    logic [DATA_W-1:0] head_data;
    logic [REG_W-1:0]  head_rd;
    logic              head_we;
    logic              accept;
    logic              pop;
    logic              entry_we;

    // in_ready sees only registered state so rf_ready never reaches the ALU side.
    assign in_ready = !reset && (count != 2'd2) && !exc_pending;
    assign accept   = in_valid && in_ready;
    assign entry_we = in_wen && (in_rd != '0) && !in_result[FLAG_OVF];

    // Non-writing heads retire without waiting for the register file.
    assign pop      = (count != 2'd0) && (!head_we || rf_ready);
    assign rf_we    = (count != 2'd0) && head_we;
    assign rf_addr  = head_rd;
    assign rf_wdata = head_data;

    wb_fifo #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (in_result[DATA_W-1:0]),
        .push_rd   (in_rd),
        .push_we   (entry_we),
        .pop       (pop),
        .count     (count),
        .head_data (head_data),
        .head_rd   (head_rd),
        .head_we   (head_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            flags       <= 3'b000;
            exc_pending <= 1'b0;
            exc_func    <= '0;
            exc_rd      <= '0;
        end else begin
            if (accept) begin
                if (in_func == FUNC_SUB) begin
                    flags[0] <= in_result[FLAG_ABOVE];
                    flags[1] <= in_result[FLAG_EQUALS];
                end
                if (updates_ovf(in_func)) begin
                    flags[2] <= in_result[FLAG_OVF];
                end
            end
            // Intake is stalled while pending, so a new fault and a clear never coincide.
            if (accept && in_result[FLAG_OVF]) begin
                exc_pending <= 1'b1;
                exc_func    <= in_func;
                exc_rd      <= in_rd;
            end else if (exc_clear) begin
                exc_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [34:0] in_result;
    logic [5:0]  in_func;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        rf_ready;
    logic [2:0]  flags;
    logic        exc_pending;
    logic [5:0]  exc_func;
    logic [4:0]  exc_rd;
    logic        exc_clear;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_MUL = 6'b011000;
    localparam logic [5:0] F_DIV = 6'b011010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_NOT = 6'b100111;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(32), .REG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_func     (in_func),
        .in_rd       (in_rd),
        .in_wen      (in_wen),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .rf_ready    (rf_ready),
        .flags       (flags),
        .exc_pending (exc_pending),
        .exc_func    (exc_func),
        .exc_rd      (exc_rd),
        .exc_clear   (exc_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] rd,
                         input logic [31:0] d, input logic ovf, input logic eq,
                         input logic above, input logic wen);
        in_valid  = v;
        in_func   = f;
        in_rd     = rd;
        in_result = {ovf, eq, above, d};
        in_wen    = wen;
    endtask

    // Reference model: a plain queue of pending writes plus architectural state.
    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    ent_t        mq[$];
    logic [2:0]  m_flags;
    logic        m_pend;
    logic [5:0]  m_func;
    logic [4:0]  m_rd;
    bit          started = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mq.delete();
                m_flags = 3'b000;
                m_pend  = 1'b0;
                m_func  = '0;
                m_rd    = '0;
                started = 1;
            end else begin
                bit   acc;
                ent_t e;
                acc = in_valid && (mq.size() < 2) && !m_pend;
                if (mq.size() > 0 && (!mq[0].we || rf_ready))
                    void'(mq.pop_front());
                if (acc) begin
                    e.d  = in_result[31:0];
                    e.rd = in_rd;
                    e.we = in_wen && (in_rd != 0) && !in_result[34];
                    mq.push_back(e);
                    if (in_func == F_SUB) begin
                        m_flags[0] = in_result[32];
                        m_flags[1] = in_result[33];
                    end
                    if (in_func == F_ADD || in_func == F_SUB || in_func == F_MUL || in_func == F_DIV)
                        m_flags[2] = in_result[34];
                    if (in_result[34]) begin
                        m_pend = 1'b1;
                        m_func = in_func;
                        m_rd   = in_rd;
                    end else if (exc_clear) begin
                        m_pend = 1'b0;
                    end
                end else if (exc_clear) begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                logic exp_we;
                exp_we = (mq.size() > 0) && mq[0].we;
                chk("m_in_ready", in_ready, !reset && (mq.size() < 2) && !m_pend);
                chk("m_rf_we", rf_we, exp_we);
                if (exp_we) begin
                    chk("m_rf_addr", rf_addr, mq[0].rd);
                    chk("m_rf_wdata", rf_wdata, mq[0].d);
                end
                chk("m_flags", flags, m_flags);
                chk("m_exc_pending", exc_pending, m_pend);
                chk("m_exc_func", exc_func, m_func);
                chk("m_exc_rd", exc_rd, m_rd);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        rf_ready  = 1'b0;
        exc_clear = 1'b0;
        drive(0, '0, '0, '0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flags", flags, 0);
        chk("rst_exc_pending", exc_pending, 0);
        chk("rst_in_ready_held", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready_rel", in_ready, 1);

        // back-to-back ADDs
        rf_ready = 1'b1;
        drive(1, F_ADD, 5'd3, 32'd5, 0, 0, 0, 1);
        tick();
        chk("b2b_we0", rf_we, 1);
        chk("b2b_addr0", rf_addr, 3);
        chk("b2b_data0", rf_wdata, 5);
        drive(1, F_ADD, 5'd4, 32'd7, 0, 0, 0, 1);
        tick();
        chk("b2b_we1", rf_we, 1);
        chk("b2b_addr1", rf_addr, 4);
        chk("b2b_data1", rf_wdata, 7);
        in_valid = 1'b0;
        tick();
        chk("b2b_idle", rf_we, 0);

        // backpressure with three offers
        rf_ready = 1'b0;
        drive(1, F_OR, 5'd5, 32'h11, 0, 0, 0, 1);
        tick();
        chk("bp_ready1", in_ready, 1);
        drive(1, F_OR, 5'd6, 32'h22, 0, 0, 0, 1);
        tick();
        chk("bp_full", in_ready, 0);
        drive(1, F_OR, 5'd7, 32'h33, 0, 0, 0, 1);
        tick();
        chk("bp_stall", in_ready, 0);
        chk("bp_hold_addr", rf_addr, 5);
        chk("bp_hold_data", rf_wdata, 32'h11);
        rf_ready = 1'b1;
        tick();
        chk("bp_second", rf_addr, 6);
        chk("bp_reopen", in_ready, 1);
        tick();
        chk("bp_third_addr", rf_addr, 7);
        chk("bp_third_data", rf_wdata, 32'h33);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", rf_we, 0);

        // flags: SUB then AND
        drive(1, F_SUB, 5'd1, 32'h0, 0, 1, 0, 0);
        tick();
        chk("flags_sub", flags, 3'b010);
        drive(1, F_AND, 5'd1, 32'h0, 0, 0, 1, 0);
        tick();
        chk("flags_and", flags, 3'b010);

        // overflow exception
        drive(1, F_ADD, 5'd9, 32'h1234, 1, 0, 0, 1);
        tick();
        chk("exc_pend", exc_pending, 1);
        chk("exc_func", exc_func, 6'b100000);
        chk("exc_rd", exc_rd, 9);
        chk("exc_ready", in_ready, 0);
        chk("exc_no_write", rf_we, 0);
        chk("exc_flags", flags, 3'b110);
        in_valid  = 1'b0;
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        chk("exc_cleared", exc_pending, 0);
        chk("exc_ready_back", in_ready, 1);
        chk("exc_func_hold", exc_func, 6'b100000);

        // write to r0 never reaches the register file
        drive(1, F_ADD, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1);
        tick();
        chk("r0_no_we", rf_we, 0);
        in_valid = 1'b0;
        tick();
        chk("r0_no_we2", rf_we, 0);
        chk("r0_flags", flags, 3'b010);

        // reset mid-operation
        rf_ready = 1'b0;
        drive(1, F_ADD, 5'd10, 32'hAA, 0, 0, 0, 1);
        tick();
        drive(1, F_ADD, 5'd12, 32'hBB, 1, 0, 0, 1);
        tick();
        chk("mr_pend", exc_pending, 1);
        chk("mr_head", rf_addr, 10);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("mr_ready_in_reset", in_ready, 0);
        tick();
        chk("mr_rf_we", rf_we, 0);
        chk("mr_rf_addr", rf_addr, 0);
        chk("mr_rf_wdata", rf_wdata, 0);
        chk("mr_flags", flags, 0);
        chk("mr_pend_clr", exc_pending, 0);
        chk("mr_exc_func", exc_func, 0);
        chk("mr_exc_rd", exc_rd, 0);
        reset = 1'b0;
        #1;
        chk("mr_ready_after", in_ready, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] fsel [8];
            tick();
            fsel = '{F_ADD, F_SUB, F_MUL, F_DIV, F_AND, F_OR, F_NOT, 6'(($urandom)) };
            in_valid  = ($urandom % 4) != 0;
            in_func   = fsel[$urandom % 8];
            in_rd     = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
            in_result = {(($urandom % 10) == 0), 1'($urandom), 1'($urandom), 32'($urandom)};
            in_wen    = ($urandom % 4) != 0;
            rf_ready  = ($urandom % 3) != 0;
            exc_clear = ($urandom % 5) == 0;
            reset     = ($urandom % 250) == 0;
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
